// File: rtl/tdm_lif_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: one shared update datapath, one neuron per clock.
// Optional feature: define REFRACTORY_EN to add per-neuron refractory counters.
module tdm_lif_array #(
  parameter int N_NEURONS   = 4,
  parameter int WIDTH       = 8,
  parameter int THRESHOLD   = 200,
  parameter int DECAY_SHIFT = 1,
  parameter int REFRACT     = 2,
  localparam int IDX_W      = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     ext_current,
  input  logic [N_NEURONS-1:0] chain_mask,
  input  logic [IDX_W-1:0]     sel,
  output logic [WIDTH-1:0]     state_out,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 frame_valid
);

  typedef logic [WIDTH-1:0] word_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  word_t                state_q [N_NEURONS];
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_NEURONS-1:0] shadow_q, shadow_d;
  logic [N_NEURONS-1:0] spike_vec_q;
  logic                 frame_valid_q;
  word_t                state_out_q;

  logic [IDX_W-1:0]     prev_idx;
  word_t                cur_state, in_cur, leak, sum_sat, state_d;
  logic [WIDTH:0]       sum_w;
  logic                 fire, last;

`ifdef REFRACTORY_EN
  localparam int REF_W = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  logic [REF_W-1:0] refr_q [N_NEURONS];
  logic [REF_W-1:0] refr_d;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    prev_idx  = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
    cur_state = state_q[idx_q];
    in_cur    = ext_current;
    if (idx_q != '0 && chain_mask[idx_q]) in_cur = state_q[prev_idx];

    // Leak term is at most s, so the subtraction cannot underflow; the add carries into bit WIDTH.
    leak    = cur_state - (cur_state >> DECAY_SHIFT);
    sum_w   = {1'b0, leak} + {1'b0, in_cur};
    sum_sat = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
    fire    = (sum_sat >= word_t'(THRESHOLD));
    state_d = fire ? '0 : sum_sat;

`ifdef REFRACTORY_EN
    refr_d = fire ? REF_W'(REFRACT) : '0;
    if (refr_q[idx_q] != '0) begin
      fire    = 1'b0;
      state_d = '0;
      refr_d  = refr_q[idx_q] - 1'b1;
    end
`endif

    last            = (idx_q == LAST_IDX);
    idx_d           = last ? '0 : idx_q + 1'b1;
    shadow_d        = shadow_q;
    shadow_d[idx_q] = fire;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the state file is a handful of registers that must read zero after reset, so it is reset explicitly.
      for (int k = 0; k < N_NEURONS; k++) begin
        state_q[k] <= '0;
`ifdef REFRACTORY_EN
        refr_q[k]  <= '0;
`endif
      end
      idx_q         <= '0;
      shadow_q      <= '0;
      spike_vec_q   <= '0;
      frame_valid_q <= 1'b0;
      state_out_q   <= '0;
    end else begin
      // Readout samples before this edge's write: the new value shows up one cycle later.
      state_out_q   <= ({1'b0, sel} < (IDX_W + 1)'(N_NEURONS)) ? state_q[sel] : '0;
      frame_valid_q <= 1'b0;
      if (en) begin
        state_q[idx_q] <= state_d;
`ifdef REFRACTORY_EN
        refr_q[idx_q]  <= refr_d;
`endif
        idx_q <= idx_d;
        if (last) begin
          spike_vec_q   <= shadow_d;
          shadow_q      <= '0;
          frame_valid_q <= 1'b1;
        end else begin
          shadow_q <= shadow_d;
        end
      end
    end
  end

  assign state_out   = state_out_q;
  assign spike_vec   = spike_vec_q;
  assign frame_valid = frame_valid_q & en;

endmodule

// File: tb/tb_tdm_lif_array.sv
// Self-checking bench for tdm_lif_array: behavioural reference model plus a spike-frame scoreboard.
// Build with REFRACTORY_EN defined to exercise the refractory configuration.
module tb_tdm_lif_array;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TH = 200;
  localparam int RF = 2;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [W-1:0] ext_current;
  logic [N-1:0] chain_mask;
  logic [1:0]   sel;
  logic [W-1:0] state_out;
  logic [N-1:0] spike_vec;
  logic         frame_valid;

  always #5 clk = ~clk;

  tdm_lif_array #(
    .N_NEURONS(N), .WIDTH(W), .THRESHOLD(TH), .DECAY_SHIFT(1), .REFRACT(RF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ext_current(ext_current), .chain_mask(chain_mask),
    .sel(sel), .state_out(state_out), .spike_vec(spike_vec), .frame_valid(frame_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the array
  int           m_state [N];
  int           m_ref   [N];
  int           m_idx;
  logic [N-1:0] m_shadow;
  logic         m_fv_q;
  int           m_so;
  logic [N-1:0] sb_q [$];

  // What the DUT showed in the most recent cycle
  logic         last_fv;
  logic [W-1:0] last_so;
  logic [N-1:0] last_sv;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_state[k] = 0;
      m_ref[k]   = 0;
    end
    m_idx    = 0;
    m_shadow = '0;
    m_fv_q   = 1'b0;
  endtask

  // Drive one clock of stimulus, advance the model, then compare outputs mid-cycle.
  task automatic cycle(input logic r, input logic e, input logic [W-1:0] x,
                       input logic [N-1:0] c, input logic [1:0] s);
    int k, in_v, sum;
    logic spk;
    rst = r; en = e; ext_current = x; chain_mask = c; sel = s;

    m_so = m_state[s];
    if (r) begin
      model_reset();
      m_so = 0;
      sb_q.delete();
    end else begin
      m_fv_q = 1'b0;
      if (e) begin
        k    = m_idx;
        in_v = (k != 0 && c[k]) ? m_state[k-1] : int'(x);
        if (m_ref[k] != 0) begin
          m_ref[k]--;
          m_state[k] = 0;
          spk = 1'b0;
        end else begin
          sum = m_state[k] - m_state[k] / 2 + in_v;
          if (sum > 255) sum = 255;
          spk = (sum >= TH);
          m_state[k] = spk ? 0 : sum;
`ifdef REFRACTORY_EN
          if (spk) m_ref[k] = RF;
`endif
        end
        m_shadow[k] = spk;
        if (k == N - 1) begin
          sb_q.push_back(m_shadow);
          m_shadow = '0;
          m_fv_q   = 1'b1;
        end
        m_idx = (k + 1) % N;
      end
    end

    @(posedge clk);
    @(negedge clk);

    check("state_out", state_out, m_so);
    check("frame_valid", frame_valid, m_fv_q & e);
    if (m_fv_q && !e && sb_q.size() > 0) sb_q.pop_front();
    if (frame_valid) begin
      check("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) check("spike_vec", spike_vec, sb_q.pop_front());
    end
    if (r) check("rst_spike_vec", spike_vec, 0);
    last_fv = frame_valid;
    last_so = state_out;
    last_sv = spike_vec;
  endtask

  task automatic peek(input logic [1:0] s, output logic [W-1:0] v);
    cycle(1'b0, 1'b0, '0, '0, s);
    v = last_so;
  endtask

  task automatic run_frame(input logic [W-1:0] x, input logic [N-1:0] c, input logic [1:0] s);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, x, c, s);
  endtask

  initial begin
    int           fv_cnt;
    logic [W-1:0] v;
    int           t2_tab [7] = '{100, 150, 175, 188, 194, 197, 199};
    model_reset();

    // 1: reset then idle frames with zero input
    cycle(1'b1, 1'b0, '0, '0, 2'd0);
    cycle(1'b1, 1'b0, '0, '0, 2'd0);
    check("t1_state_out_rst", state_out, 0);
    fv_cnt = 0;
    for (int i = 0; i < 3 * N; i++) begin
      cycle(1'b0, 1'b1, '0, '0, 2'(i));
      if (last_fv) fv_cnt++;
      check("t1_fv_phase", last_fv, ((i % N) == N - 1));
    end
    check("t1_fv_count", fv_cnt, 3);
    check("t1_spike_vec", last_sv, 0);

    // 2: leaky integration of neuron 0
    cycle(1'b1, 1'b0, '0, '0, 2'd0);
    for (int f = 0; f < 8; f++) begin
      run_frame(8'd100, '0, 2'd0);
      check("t2_fv", last_fv, 1);
      if (f < 7) begin
        check("t2_state0", last_so, t2_tab[f]);
        check("t2_no_spike0", last_sv[0], 0);
      end else begin
        check("t2_spike0", last_sv[0], 1);
        peek(2'd0, v);
        check("t2_state0_after_spike", v, 0);
      end
    end

    // 3: supra-threshold input on every neuron
    cycle(1'b1, 1'b0, '0, '0, 2'd0);
    for (int f = 0; f < 3; f++) begin
      run_frame(8'd210, '0, 2'(f));
`ifdef REFRACTORY_EN
      check("t3_spike_vec", last_sv, (f == 0) ? 4'hF : 4'h0);
`else
      check("t3_spike_vec", last_sv, 4'hF);
`endif
    end
    for (int s = 0; s < N; s++) begin
      peek(2'(s), v);
      check("t3_state_zero", v, 0);
    end

    // 4: chain from neuron 0 into neuron 1
    cycle(1'b1, 1'b0, '0, '0, 2'd0);
    run_frame(8'd150, 4'b0010, 2'd0);
    peek(2'd0, v); check("t4_f1_state0", v, 150);
    peek(2'd1, v); check("t4_f1_state1", v, 150);
    run_frame(8'd150, 4'b0010, 2'd0);
    check("t4_f2_spike0", last_sv[0], 1);
    check("t4_f2_spike1", last_sv[1], 0);
    peek(2'd0, v); check("t4_f2_state0", v, 0);
    peek(2'd1, v); check("t4_f2_state1", v, 75);

    // 5: pause mid-frame, resume, then reset mid-frame
    cycle(1'b1, 1'b0, '0, '0, 2'd0);
    for (int f = 0; f < 3; f++) run_frame(8'd100, '0, 2'd0);
    cycle(1'b0, 1'b1, 8'd100, '0, 2'd0);
    cycle(1'b0, 1'b1, 8'd100, '0, 2'd0);
    fv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 8'd100, '0, 2'd0);
      if (last_fv) fv_cnt++;
    end
    check("t5_pause_no_fv", fv_cnt, 0);
    check("t5_pause_state0", last_so, 188);
    check("t5_pause_spike_vec", last_sv, 0);
    cycle(1'b0, 1'b1, 8'd100, '0, 2'd0);
    check("t5_resume_no_fv_yet", last_fv, 0);
    cycle(1'b0, 1'b1, 8'd100, '0, 2'd0);
    check("t5_resume_fv", last_fv, 1);
    cycle(1'b0, 1'b1, 8'd100, '0, 2'd0);
    cycle(1'b0, 1'b1, 8'd100, '0, 2'd0);
    cycle(1'b1, 1'b1, 8'd100, '0, 2'd0);
    check("t5_rst_state_out", last_so, 0);
    check("t5_rst_fv", last_fv, 0);
    for (int s = 0; s < N; s++) begin
      peek(2'(s), v);
      check("t5_rst_state_zero", v, 0);
    end
    fv_cnt = 0;
    for (int i = 0; i < N - 1; i++) begin
      cycle(1'b0, 1'b1, 8'd100, '0, 2'd0);
      if (last_fv) fv_cnt++;
    end
    check("t5_no_partial_fv", fv_cnt, 0);
    cycle(1'b0, 1'b1, 8'd100, '0, 2'd0);
    check("t5_first_full_frame_fv", last_fv, 1);

`ifdef REFRACTORY_EN
    // 6: refractory pattern on neuron 0
    cycle(1'b1, 1'b0, '0, '0, 2'd0);
    for (int f = 0; f < 6; f++) begin
      run_frame(8'd210, '0, 2'd0);
      check("t6_refr_spike0", last_sv[0], (f % 3) == 0);
    end
`endif

    // Randomised traffic against the model
    cycle(1'b1, 1'b0, '0, '0, 2'd0);
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
            (($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom)),
            4'($urandom), 2'($urandom));
    end
    cycle(1'b0, 1'b0, '0, '0, 2'd0);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
